// File: rtl/axi_pkg.sv
// Shared AXI constants and the burst-writer FSM state type.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Bursts must not cross a 2**AXI_4K_BITS byte boundary
    localparam int unsigned AXI_4K_BITS = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_FIN
    } wr_state_t;

endpackage

// File: rtl/axi_wr_skid_buf.sv
// Two-entry holding buffer between the FIFO read port and the AXI W channel.
module axi_wr_skid_buf #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_fifo_burst_writer.sv
// Drains a FIFO into memory as AXI4 INCR write bursts, one burst outstanding.
// Optional performance counters: define AXI_FIFO_BURST_WRITER_PERF_EN.
module axi_fifo_burst_writer
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [CNT_WIDTH-1:0]    total_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_empty,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
`ifdef AXI_FIFO_BURST_WRITER_PERF_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [15:0]             burst_count
`endif
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG2 = $clog2(BYTES);
    localparam int unsigned BW        = AXI_4K_BITS + 1;

    wr_state_t             state, state_next;
    logic                  busy_q;
    logic                  error_q;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic [CNT_WIDTH-1:0]  job_total_q;
    logic [CNT_WIDTH-1:0]  popped_q;
    logic [8:0]            beat_q;

    logic [8:0]            burst_len;
    logic [BW-1:0]         to_bnd;
    logic [BW-1:0]         bnd_beats;
    logic [CNT_WIDTH-1:0]  remaining_after;
    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  start_accept;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  b_fire;
    logic                  b_err;

    // Length is a pure function of addr_q/remaining_q, which only move on B,
    // so it stays stable through AW, W and B without its own register.
    always_comb begin
        to_bnd    = BW'(1 << AXI_4K_BITS) - {1'b0, addr_q[AXI_4K_BITS-1:0]};
        bnd_beats = to_bnd >> SIZE_LOG2;
        burst_len = 9'(MAX_BURST);
        if (32'(remaining_q) < 32'(burst_len)) begin
            burst_len = 9'(remaining_q);
        end
        if (32'(bnd_beats) < 32'(burst_len)) begin
            burst_len = 9'(bnd_beats);
        end
    end

    assign remaining_after = remaining_q - CNT_WIDTH'(burst_len);
    assign start_accept    = (state == ST_IDLE) && !busy_q && start;
    assign aw_fire         = m_awvalid && m_awready;
    assign w_fire          = m_wvalid && m_wready;
    assign b_fire          = m_bvalid && m_bready;
    assign b_err           = (m_bresp != AXI_RESP_OKAY);

    assign busy      = busy_q;
    assign done      = (state == ST_FIN);
    assign error     = error_q;
    assign m_awaddr  = (state == ST_AW) ? addr_q : '0;
    assign m_awlen   = (state == ST_AW) ? 8'(burst_len - 9'd1) : '0;
    assign m_awsize  = 3'(SIZE_LOG2);
    assign m_awburst = AXI_BURST_INCR;
    assign m_awvalid = (state == ST_AW);
    assign m_wdata   = buf_data;
    assign m_wstrb   = '1;
    assign m_wvalid  = (state == ST_W) && (buf_count != 2'd0);
    assign m_wlast   = (state == ST_W) && (beat_q == burst_len - 9'd1);
    assign m_bready  = (state == ST_B);

    // A beat leaving the buffer this cycle frees a slot, which is what lets
    // the fetch path keep up at one word per clock.
    assign fifo_rd_en = busy_q && !fifo_empty && (popped_q < job_total_q) &&
                        ({1'b0, buf_count} + {2'b0, inflight_q} < 3'd2 + {2'b0, w_fire});

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (busy_q) begin
                    state_next = (job_total_q == '0) ? ST_FIN : ST_AW;
                end
            end
            ST_AW: begin
                if (aw_fire) begin
                    state_next = ST_W;
                end
            end
            ST_W: begin
                if (w_fire && m_wlast) begin
                    state_next = ST_B;
                end
            end
            ST_B: begin
                if (b_fire) begin
                    if ((remaining_after != '0) && !b_err && !error_q) begin
                        state_next = ST_AW;
                    end else begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            inflight_q  <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            job_total_q <= '0;
            popped_q    <= '0;
            beat_q      <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (start_accept) begin
                busy_q      <= 1'b1;
                error_q     <= 1'b0;
                addr_q      <= base_addr;
                remaining_q <= total_beats;
                job_total_q <= total_beats;
                popped_q    <= '0;
            end
            if (fifo_rd_en) begin
                popped_q <= popped_q + 1'b1;
            end
            if (aw_fire) begin
                beat_q <= '0;
            end else if (w_fire) begin
                beat_q <= beat_q + 9'd1;
            end
            if (b_fire) begin
                if (b_err) begin
                    error_q <= 1'b1;
                end
                addr_q      <= addr_q + (ADDR_WIDTH'(burst_len) << SIZE_LOG2);
                remaining_q <= remaining_after;
            end
            if (state_next == ST_FIN) begin
                busy_q <= 1'b0;
            end
        end
    end

    axi_wr_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start_accept),
        .push      (inflight_q),
        .push_data (fifo_rd_data),
        .pop       (w_fire),
        .count     (buf_count),
        .head_data (buf_data)
    );

`ifdef AXI_FIFO_BURST_WRITER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            burst_count  <= '0;
        end else if (start_accept) begin
            stall_cycles <= '0;
            burst_count  <= '0;
        end else begin
            if ((state == ST_W) && !m_wvalid && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (b_fire && (burst_count != '1)) begin
                burst_count <= burst_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/axi_fifo_burst_writer.md
Name: axi_fifo_burst_writer

Overview:
- Drain stage directly downstream of the synchronous FIFO. Pops words from the FIFO read port and writes them to memory as AXI4 INCR write bursts.
- Software or bench supplies a base address and a word count, pulses start, then waits for done.
- One outstanding burst at a time: AW, then all W beats, then B.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI/FIFO data width; must equal FIFO WIDTH; power of two, 8..128.
- MAX_BURST, 16, maximum beats per burst, 1..256.
- CNT_WIDTH, 16, width of the word-count input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request; ignored while busy.
- base_addr  in  ADDR_WIDTH  job start address; must be DATA_WIDTH/8 aligned.
- total_beats  in  CNT_WIDTH  number of words in the job.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- error  out  1  sticky per job: a non-OKAY BRESP was seen; cleared on start.
- fifo_rd_en  out  1  FIFO pop request.
- fifo_rd_data  in  DATA_WIDTH  FIFO data; valid the cycle after an accepted pop.
- fifo_empty  in  1  FIFO empty flag.
- m_awaddr/m_awlen[7:0]/m_awsize[2:0]/m_awburst[1:0]/m_awvalid  out; m_awready in.
- m_wdata/m_wstrb/m_wlast/m_wvalid  out; m_wready in.
- m_bresp[1:0]/m_bvalid  in; m_bready out.

Behaviour:
- Reset values: all outputs 0. m_awsize = log2(DATA_WIDTH/8) constant; m_awburst = 2'b01 constant; m_wstrb = all ones constant.
- FSM states: IDLE, AW, W, B, FIN.
- IDLE: start latches base_addr and total_beats, clears error, and sets busy. Goes to AW next cycle; with total_beats = 0 it goes to FIN instead.
- Burst length = min(MAX_BURST, remaining, beats left before the next 4 KB boundary). awlen = length - 1.
- AW: awvalid held until awready; awaddr/awlen stable while valid. Goes to W.
- W: streams exactly length beats; wlast on the final beat. Goes to B after the wlast handshake.
- B: bready = 1. On bvalid:
  - bresp != 2'b00 sets error.
  - Address advances by length*DATA_WIDTH/8; remaining decrements by length.
  - Goes to AW if remaining > 0 and no error, else FIN.
- FIN: done = 1 for one cycle, busy = 0. Goes to IDLE.
- Error aborts the job after the current burst completes. The FIFO is not flushed.
- Fetch path: a 2-entry holding buffer feeds W.
  - fifo_rd_en = busy && !fifo_empty && (buffered + in-flight) < 2 && (popped < job beats).
  - Popped data lands in the buffer one cycle after the pop.
  - wvalid = buffer non-empty && state == W.
  - Sustains 1 beat/clk when the FIFO stays non-empty and wready = 1.
- Prefetch across burst boundaries is allowed, but the block never pops more than total_beats per job.
- FIFO underrun mid-burst: wvalid drops; wdata/wlast are unchanged while wvalid && !wready.
- start during busy: ignored, no side effects.
- Reset mid-burst: everything returns to reset state immediately. The AXI slave must also be reset; words already popped are lost.

Optional Feature:
- Macro: AXI_FIFO_BURST_WRITER_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and burst_count[15:0].
  - stall_cycles counts cycles in W with wvalid = 0.
  - burst_count counts completed B handshakes.
  - Both clear on start and saturate at all ones.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package axi_pkg:
  - AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
  - Writer FSM state typedef.
  - Constant 4 KB boundary width of 12.
- One sub-module: axi_wr_skid_buf, the 2-entry holding buffer with push/pop/count and pass-through of data to wdata.

Test Plan:
- base 0x1000, total 40, FIFO prefilled, wready/awready always 1 -> 3 bursts, awlen 15/15/7, addrs 0x1000/0x1040/0x1080; done after the third B; data in order.
- base 0x0FF8, total 8 -> awlen 1 at 0x0FF8, then awlen 5 at 0x1000 (4 KB split).
- total 0 -> done pulses 2 cycles after start; no awvalid; fifo_rd_en never asserted.
- FIFO empty for 5 cycles after the 3rd beat, and wready toggled randomly -> wvalid low during the gap; wdata stable under backpressure; exactly 16 pops.
- bresp = 2'b10 on the first of 3 bursts -> error = 1; no second AW; done pulses; 16 words popped, or up to 18 with prefetch.
- rst_n low during the W state -> all AXI valids and busy low asynchronously; after release, a new job of 4 words completes correctly.
